// File: rtl/serial_addsub_ctrl_if.sv
// rtl/serial_addsub_ctrl_if.sv - request/result bundle for the bit-serial add/subtract controller
interface serial_addsub_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;

    // Requesting unit: drives the operation, observes status and result
    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow
    );

    // Controller: accepts the operation, presents status and result
    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial N-bit add/subtract over one shared 1-bit full adder
module full_adder1b (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_addsub_ctrl #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_ctrl_if.slave  bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          w_load;
    logic          w_last;

    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_sh;
    logic          r_c;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;

    logic          w_s;
    logic          w_fa_cout;

    // The single shared adder sees the current LSBs and the running carry
    full_adder1b u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_c),
        .o_s    (w_s),
        .o_cout (w_fa_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control: start is honoured only in IDLE and DONE
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_BIT) begin
                    w_last       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands (B inverted with carry-in 1 for subtract), then shift one bit per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_sh   <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_load) begin
            r_a_sh <= bus.a;
            r_b_sh <= bus.sub ? ~bus.b : bus.b;
            r_c    <= bus.sub;
            r_cnt  <= '0;
            r_sh   <= '0;
        end else if (r_state == S_RUN) begin
            r_sh   <= {w_s, r_sh[N-1:1]};
            r_a_sh <= {1'b0, r_a_sh[N-1:1]};
            r_b_sh <= {1'b0, r_b_sh[N-1:1]};
            r_c    <= w_fa_cout;
            r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                // r_c here is the carry into the MSB
                r_sum  <= {w_s, r_sh[N-1:1]};
                r_cout <= w_fa_cout;
                r_ovf  <= r_c ^ w_fa_cout;
            end
        end
    end

    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl
module tb_serial_addsub_ctrl;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [N-1:0] h_sum;
    logic         h_cout;
    logic         h_ovf;
    logic [N-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;

    logic [N-1:0] ra, rb, na, nb;
    logic         rs, ns, ch;
    int           seen_done;

    serial_addsub_ctrl_if #(.N(N)) bus ();

    serial_addsub_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain N+1-bit arithmetic and the signed-overflow rule on operand/result signs
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        logic [N:0]   full;
        logic [N-1:0] bb;
        bb   = sub ? (~b) : b;
        full = {1'b0, a} + {1'b0, bb} + (N+1)'(sub);
        e_sum  = full[N-1:0];
        e_cout = full[N];
        if (sub) e_ovf = (a[N-1] != b[N-1]) && (e_sum[N-1] != a[N-1]);
        else     e_ovf = (a[N-1] == b[N-1]) && (e_sum[N-1] != a[N-1]);
    endtask

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.start = 1'b1;
        model(a, b, sub);
        tick();
        bus.start = 1'b0;
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
        bus.sub   = 1'($urandom);
    endtask

    // Called in the cycle after the start edge; walks the N busy cycles and checks the done cycle
    task automatic finish_op(input bit inject, input bit chain,
                             input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xs);
        for (int i = 0; i < N; i++) begin
            check("busy_run", 32'(bus.busy), 32'd1);
            check("done_run", 32'(bus.done), 32'd0);
            check("sum_held", 32'(bus.sum), 32'(h_sum));
            check("cout_held", 32'(bus.cout), 32'(h_cout));
            if (inject && i == 2) begin
                bus.a     = N'($urandom);
                bus.b     = N'($urandom);
                bus.sub   = ~bus.sub;
                bus.start = 1'b1;
            end
            if (inject && i == 3) bus.start = 1'b0;
            tick();
        end
        check("done_pulse", 32'(bus.done), 32'd1);
        check("busy_done", 32'(bus.busy), 32'd0);
        check("sum", 32'(bus.sum), 32'(e_sum));
        check("cout", 32'(bus.cout), 32'(e_cout));
        check("overflow", 32'(bus.overflow), 32'(e_ovf));
        h_sum  = e_sum;
        h_cout = e_cout;
        h_ovf  = e_ovf;
        if (chain) begin
            launch(xa, xb, xs);
        end else begin
            tick();
            check("done_single", 32'(bus.done), 32'd0);
            check("busy_idle", 32'(bus.busy), 32'd0);
            check("sum_idle", 32'(bus.sum), 32'(h_sum));
            check("ovf_idle", 32'(bus.overflow), 32'(h_ovf));
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        h_sum     = '0;
        h_cout    = 1'b0;
        h_ovf     = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors, with the constants from the worked examples checked too
        launch(8'h5A, 8'h3C, 1'b0);
        finish_op(0, 0, '0, '0, 0);
        check("ex1_sum", 32'(h_sum), 32'h96);
        launch(8'hFF, 8'h01, 1'b0);
        finish_op(0, 0, '0, '0, 0);
        check("ex2_sum", 32'(h_sum), 32'h00);
        launch(8'h7F, 8'h7F, 1'b0);
        finish_op(0, 0, '0, '0, 0);
        check("ex3_ovf", 32'(h_ovf), 32'd1);
        launch(8'h10, 8'h20, 1'b1);
        finish_op(0, 0, '0, '0, 0);
        check("ex4_sum", 32'(h_sum), 32'hF0);
        launch(8'h80, 8'h01, 1'b1);
        finish_op(0, 0, '0, '0, 0);
        check("ex5_sum", 32'(h_sum), 32'h7F);

        // Start during RUN must be ignored
        launch(8'h12, 8'h34, 1'b0);
        finish_op(1, 0, '0, '0, 0);
        check("ignore_sum", 32'(h_sum), 32'h46);

        // Reset mid-run discards the operation
        launch(8'hA5, 8'h5A, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_done", 32'(bus.done), 32'd0);
        check("mrst_sum", 32'(bus.sum), 32'd0);
        check("mrst_cout", 32'(bus.cout), 32'd0);
        check("mrst_ovf", 32'(bus.overflow), 32'd0);
        h_sum  = '0;
        h_cout = 1'b0;
        h_ovf  = 1'b0;
        seen_done = 0;
        for (int i = 0; i < N + 3; i++) begin
            if (bus.done === 1'b1) seen_done++;
            tick();
        end
        check("mrst_no_done", 32'(seen_done), 32'd0);
        launch(8'h33, 8'h44, 1'b1);
        finish_op(0, 0, '0, '0, 0);

        // Back-to-back: start held in the done cycle
        launch(8'hC8, 8'h64, 1'b0);
        finish_op(0, 1, 8'h01, 8'h02, 1'b1);
        finish_op(0, 0, '0, '0, 0);

        // Randomised operations, randomly chained
        ra = N'($urandom);
        rb = N'($urandom);
        rs = 1'($urandom);
        launch(ra, rb, rs);
        for (int k = 0; k < 24; k++) begin
            na = N'($urandom);
            nb = N'($urandom);
            ns = 1'($urandom);
            ch = (k != 23) && ($urandom_range(0, 1) == 1);
            finish_op(($urandom_range(0, 3) == 0), ch, na, nb, ns);
            if (!ch && k != 23) launch(na, nb, ns);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
